mac_array_ctrl: RTL and testbench
=================================

Name: mac_array_ctrl

Overview:
- Sequencing controller for the 2-D systolic MAC array (ROW stacked mac rows, COL tiles each).
- Generates the 3-bit west-edge instruction stream and the L0 read strobe that drive the array through five phases in order: kernel load, weight settle, execute, drain, pipelined output flush.
- Sits between the top-level core control and the array/L0 buffer, with a start/busy/done handshake toward core control.

Parameters:
- ROW, 8, number of mac rows (array height).
- COL, 8, tiles per row (array width).
- LEN_BW, 11, width of the activation-vector count and the internal phase counter.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  begin one pass; sampled only in IDLE.
- abort  input  1  synchronous abort; returns to IDLE from any state.
- x_len  input  LEN_BW  number of activation vectors; latched when start is accepted.
- l0_empty  input  1  L0 has no data this cycle; stalls the current phase.
- l0_rd  output  1  L0 read strobe.
- inst_w  output  3  instruction to the west edge of row 0 (bit0 kernel load, bit1 execute, bit2 flush).
- busy  output  1  pass in progress.
- done  output  1  one-cycle pass-complete pulse.

Behaviour:
- Reset low: state=IDLE, counter=0, x_len_q=0, busy=0, done=0, l0_rd=0, inst_w=3'b000. All outputs are held at these values while reset is low, regardless of other inputs.
- States: IDLE, WLOAD, WSETTLE, XEXEC, DRAIN, FLUSH, DONE.
- State, counter and x_len_q are registered. inst_w and l0_rd are decoded combinationally from state and l0_empty. busy and done are decoded from state.
- busy=1 in WLOAD through FLUSH. busy=0 in IDLE and DONE. done=1 only in DONE.
- Instruction encodings:
  - INST_NOP = 000
  - INST_KLOAD = 001
  - INST_EXEC = 010
  - INST_FLUSH = 101
- The mac rows flag 010 and 101 as valid outputs. The controller never emits any other code.
- IDLE: start=1 at an edge → WLOAD, counter=0, x_len_q=x_len. start while not IDLE is ignored.
- WLOAD: COL beats.
  - A beat is a cycle with l0_empty=0: l0_rd=1, inst_w=001, counter+1.
  - l0_empty=1: l0_rd=0, inst_w=000, counter holds (stall; any number of stall cycles allowed).
  - Completion of beat COL → WSETTLE, counter=0.
- WSETTLE: ROW+COL-1 cycles, inst_w=000, l0_rd=0, no stall. Then → XEXEC, or → DRAIN if x_len_q==0.
- XEXEC: x_len_q beats, same stall rule as WLOAD but with inst_w=010. Then → DRAIN.
- DRAIN: ROW+COL-1 cycles, inst_w=000. Then → FLUSH.
- FLUSH: COL cycles, inst_w=101, l0_rd=0, no stall. Then → DONE.
- DONE: one cycle, done=1. Then → IDLE. start is not accepted during DONE; it is accepted again from the cycle after.
- abort=1 at an edge, any non-IDLE state → IDLE, counter=0. No done pulse. inst_w=000 from that edge. abort has priority over all phase transitions. abort in IDLE has no effect; abort and start together in IDLE → stays IDLE.
- Counter width is LEN_BW. Comparisons are against COL, ROW+COL-1 and x_len_q, zero-extended. x_len = 2^LEN_BW-1 is legal.
- Unstalled pass latency, counted from the start edge: COL + 2*(ROW+COL-1) + x_len + COL busy cycles, then one done cycle.
- Async reset mid-pass: immediate return to reset values. No partial flush.

Decomposition:
- Shared package mac_ctrl_pkg:
  - state enum.
  - INST_NOP / INST_KLOAD / INST_EXEC / INST_FLUSH constants.
  - Helper constant SKEW = ROW+COL-1.
- One sub-module: phase_counter.
  - Loadable up-counter with enable and clear.
  - Terminal-count compare output tc.
  - Parameter LEN_BW.
  - The FSM instantiates it once and drives its clear/enable/limit per state.

Test Plan:
- Reset, then ROW=COL=8, x_len=16, l0_empty=0, pulse start:
  - inst_w=001 for cycles 1-8, 000 for 15 cycles, 010 for 16, 000 for 15, 101 for 8.
  - done=1 in cycle 63; l0_rd high for exactly 24 cycles.
- Same pass with l0_empty=1 for 3 cycles in mid-WLOAD and 2 cycles in mid-XEXEC → inst_w=000 and l0_rd=0 on those cycles; exactly 8 KLOAD and 16 EXEC beats; done in cycle 68.
- x_len=0 → no 010 cycles; WSETTLE goes directly to DRAIN; done in cycle 47.
- abort during XEXEC beat 5 → inst_w=000 and busy=0 from the next cycle; no done pulse; a new start is accepted the cycle after.
- start held high continuously across a whole pass → ignored while busy and during DONE; a second pass begins on the first IDLE edge after DONE.
- Async reset asserted mid-FLUSH, between clock edges → busy, done, l0_rd and inst_w go to 0 immediately; after release, the FSM stays in IDLE until start.

Source files
------------

// File: rtl/mac_ctrl_pkg.sv
// rtl/mac_ctrl_pkg.sv - shared types and constants for the MAC array sequencer
package mac_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WLOAD,
        S_WSETTLE,
        S_XEXEC,
        S_DRAIN,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam logic [2:0] INST_NOP   = 3'b000;
    localparam logic [2:0] INST_KLOAD = 3'b001;
    localparam logic [2:0] INST_EXEC  = 3'b010;
    localparam logic [2:0] INST_FLUSH = 3'b101;

    // Cycles for a wavefront to cross the skewed array corner to corner
    function automatic int calc_skew(input int row, input int col);
        return row + col - 1;
    endfunction

    localparam int DEF_ROW = 8;
    localparam int DEF_COL = 8;
    localparam int SKEW    = calc_skew(DEF_ROW, DEF_COL);

endpackage

// File: rtl/mac_array_ctrl_phase_counter.sv
// rtl/mac_array_ctrl_phase_counter.sv - per-phase up-counter with terminal-count flag
module phase_counter #(
    parameter int LEN_BW = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              en,
    input  logic [LEN_BW-1:0] limit,
    output logic              tc
);

    localparam logic [LEN_BW-1:0] INC     = LEN_BW'(1);
    localparam logic [LEN_BW:0]   INC_EXT = (LEN_BW + 1)'(1);

    logic [LEN_BW-1:0] count;

    // tc flags the last step of the phase; one extra bit lets limit reach 2^LEN_BW-1
    assign tc = (({1'b0, count} + INC_EXT) == {1'b0, limit});

    // Clear wins over enable so a phase boundary always restarts at zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + INC;
        end
    end

endmodule

// File: rtl/mac_array_ctrl.sv
// rtl/mac_array_ctrl.sv - phase sequencer driving the systolic MAC array west edge
module mac_array_ctrl
    import mac_ctrl_pkg::*;
#(
    parameter int ROW    = 8,
    parameter int COL    = 8,
    parameter int LEN_BW = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [LEN_BW-1:0] x_len,
    input  logic              l0_empty,
    output logic              l0_rd,
    output logic [2:0]        inst_w,
    output logic              busy,
    output logic              done
);

    localparam logic [LEN_BW-1:0] COL_L  = LEN_BW'(COL);
    localparam logic [LEN_BW-1:0] SKEW_L = LEN_BW'(calc_skew(ROW, COL));

    state_t            state;
    logic [LEN_BW-1:0] x_len_q;
    logic [LEN_BW-1:0] limit;
    logic              en;
    logic              tc;
    logic              phase_end;
    logic              clear;

    // Per-phase length and advance condition; stallable phases only advance on an L0 beat
    always_comb begin
        limit = '0;
        en    = 1'b0;
        case (state)
            S_WLOAD:   begin limit = COL_L;   en = !l0_empty; end
            S_WSETTLE: begin limit = SKEW_L;  en = 1'b1;      end
            S_XEXEC:   begin limit = x_len_q; en = !l0_empty; end
            S_DRAIN:   begin limit = SKEW_L;  en = 1'b1;      end
            S_FLUSH:   begin limit = COL_L;   en = 1'b1;      end
            default:   begin limit = '0;      en = 1'b0;      end
        endcase
        phase_end = en && tc;
        clear     = abort || phase_end || (state == S_IDLE) || (state == S_DONE);
    end

    phase_counter #(
        .LEN_BW (LEN_BW)
    ) u_phase_counter (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .en    (en),
        .limit (limit),
        .tc    (tc)
    );

    // Phase sequencing; abort overrides every transition, including a start in IDLE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            x_len_q <= '0;
        end else if (abort) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_WLOAD;
                        x_len_q <= x_len;
                    end
                end
                S_WLOAD:   if (phase_end) state <= S_WSETTLE;
                S_WSETTLE: if (phase_end) state <= (x_len_q == '0) ? S_DRAIN : S_XEXEC;
                S_XEXEC:   if (phase_end) state <= S_DRAIN;
                S_DRAIN:   if (phase_end) state <= S_FLUSH;
                S_FLUSH:   if (phase_end) state <= S_DONE;
                S_DONE:    state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

    // West-edge instruction and L0 strobe; a stalled beat emits NOP with no read
    always_comb begin
        inst_w = INST_NOP;
        l0_rd  = 1'b0;
        case (state)
            S_WLOAD: if (!l0_empty) begin inst_w = INST_KLOAD; l0_rd = 1'b1; end
            S_XEXEC: if (!l0_empty) begin inst_w = INST_EXEC;  l0_rd = 1'b1; end
            S_FLUSH: inst_w = INST_FLUSH;
            default: inst_w = INST_NOP;
        endcase
        busy = (state != S_IDLE) && (state != S_DONE);
        done = (state == S_DONE);
    end

endmodule

// File: tb/tb_mac_array_ctrl.sv
// tb/tb_mac_array_ctrl.sv - self-checking bench for mac_array_ctrl
module tb_mac_array_ctrl;

    localparam int ROW    = 8;
    localparam int COL    = 8;
    localparam int LEN_BW = 11;
    localparam int SKW    = ROW + COL - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              abort;
    logic [LEN_BW-1:0] x_len;
    logic              l0_empty;
    logic              l0_rd;
    logic [2:0]        inst_w;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_err    = 0;
    int last_cyc;
    int last_rd;

    mac_array_ctrl #(
        .ROW    (ROW),
        .COL    (COL),
        .LEN_BW (LEN_BW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .x_len    (x_len),
        .l0_empty (l0_empty),
        .l0_rd    (l0_rd),
        .inst_w   (inst_w),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int e_inst, input int e_rd,
                              input int e_busy, input int e_done);
        check({tag, "_inst"}, int'(inst_w), e_inst);
        check({tag, "_rd"},   int'(l0_rd),  e_rd);
        check({tag, "_busy"}, int'(busy),   e_busy);
        check({tag, "_done"}, int'(done),   e_done);
    endtask

    // Reference: a pass is the ordered phase list KLOAD(COL), NOP(SKEW), EXEC(xlen),
    // NOP(SKEW), FLUSH(COL); stallable phases consume a beat only when L0 has data.
    // mode: 0 no stalls, 1 random stalls, 2 fixed 3-cycle WLOAD / 2-cycle XEXEC stalls
    task automatic run_pass(input int xlen, input int mode, input int abort_beat,
                            input bit hold, input bit rst_flush);
        int       lens[5];
        int       codes[5];
        bit       stl[5];
        int       cyc, rd_cnt, nst, rem, stall_left, trig;
        bit       emp, cut, by_abort;
        lens  = '{COL, SKW, xlen, SKW, COL};
        codes = '{1, 0, 2, 0, 5};
        stl   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        cyc = 0; rd_cnt = 0; nst = 0; cut = 1'b0; by_abort = 1'b0;

        @(negedge clk);
        start = 1'b1; abort = 1'b0; x_len = LEN_BW'(xlen);
        l0_empty = 1'($urandom_range(0, 1));
        #1 check_outs("idle", 0, 0, 0, 0);

        for (int p = 0; p < 5 && !cut; p++) begin
            rem = lens[p]; stall_left = 0; trig = -1;
            if (mode == 2 && p == 0) begin stall_left = 3; trig = 4; end
            if (mode == 2 && p == 2) begin stall_left = 2; trig = 8; end
            while (rem > 0 && !cut) begin
                @(negedge clk);
                start = hold;
                x_len = LEN_BW'($urandom);
                cyc++;
                if (stl[p]) begin
                    if (mode == 1) emp = ($urandom_range(0, 3) == 0);
                    else emp = (stall_left > 0 && rem == trig);
                end else begin
                    emp = 1'($urandom_range(0, 1));
                end
                l0_empty = emp;
                abort = (p == 2 && abort_beat >= 0 && (lens[2] - rem) == abort_beat && !emp);
                #1;
                check_outs("phase", (stl[p] && emp) ? 0 : codes[p],
                           (stl[p] && !emp) ? 1 : 0, 1, 0);
                if (l0_rd) rd_cnt++;
                if (rst_flush && p == 4 && rem == COL - 3) begin
                    #1 reset = 1'b0;
                    #1 check_outs("async_rst", 0, 0, 0, 0);
                    cut = 1'b1;
                end
                if (abort) begin cut = 1'b1; by_abort = 1'b1; end
                if (stl[p] && emp) begin
                    nst++;
                    if (stall_left > 0) stall_left--;
                end else begin
                    rem--;
                end
            end
        end

        if (by_abort) return;

        if (cut) begin
            @(negedge clk);
            start = 1'b1;
            #1 check_outs("rst_hold", 0, 0, 0, 0);
            reset = 1'b1;
            start = 1'b0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                l0_empty = 1'($urandom_range(0, 1));
                #1 check_outs("post_rst_idle", 0, 0, 0, 0);
            end
            return;
        end

        @(negedge clk);
        start = hold;
        l0_empty = 1'($urandom_range(0, 1));
        cyc++;
        #1 check_outs("done", 0, 0, 0, 1);
        check("latency", cyc, 2 * COL + 2 * SKW + xlen + 1 + nst);
        check("rd_count", rd_cnt, COL + xlen);
        last_cyc = cyc;
        last_rd  = rd_cnt;
    endtask

    initial begin
        reset = 1'b0; start = 1'b1; abort = 1'b0; x_len = 11'd16; l0_empty = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'($urandom_range(0, 1));
            l0_empty = 1'($urandom_range(0, 1));
            #1 check_outs("reset", 0, 0, 0, 0);
        end
        @(negedge clk);
        reset = 1'b1; start = 1'b0;

        run_pass(16, 0, -1, 1'b0, 1'b0);
        check("t1_done_cycle", last_cyc, 63);
        check("t1_rd_cycles", last_rd, 24);

        run_pass(16, 2, -1, 1'b0, 1'b0);
        check("t2_done_cycle", last_cyc, 68);
        check("t2_rd_cycles", last_rd, 24);

        run_pass(0, 0, -1, 1'b0, 1'b0);
        check("t3_done_cycle", last_cyc, 47);

        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        #1 check_outs("start_abort_idle", 0, 0, 0, 0);
        @(negedge clk);
        #1 check_outs("start_abort_idle2", 0, 0, 0, 0);

        run_pass(16, 1, 4, 1'b0, 1'b0);
        run_pass(5, 1, -1, 1'b0, 1'b0);

        run_pass(3, 0, -1, 1'b1, 1'b0);
        run_pass(2, 1, -1, 1'b1, 1'b0);
        @(negedge clk);
        start = 1'b0;
        #1 check_outs("after_held", 0, 0, 0, 0);

        run_pass(10, 1, -1, 1'b0, 1'b1);
        run_pass(7, 1, -1, 1'b0, 1'b0);

        for (int k = 0; k < 6; k++) begin
            run_pass($urandom_range(0, 40), 1, -1, 1'b0, 1'b0);
        end

        run_pass((1 << LEN_BW) - 1, 1, -1, 1'b0, 1'b0);

        @(negedge clk);
        start = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
